// File: rtl/cordic_dispatch.sv
// cordic_dispatch: operand FIFO, range screen and start/done sequencer for the cosine CORDIC core.
// Define CORDIC_DISPATCH_TIMEOUT_EN to add a RUN-state watchdog that aborts after TIMEOUT cycles.
module cordic_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 31
) (
    input  logic        clock,
    input  logic        aclr_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        core_clk_en,
    output logic        core_start,
    output logic [31:0] core_dataa,
    input  logic [31:0] core_result,
    input  logic        core_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_param
        $error("cordic_dispatch: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT within 1..31");
    end
    typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;
    state_t        state_q, state_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [31:0]   dataa_q, dataa_d, result_q, result_d;
    logic          err_q, err_d;
    logic          push, pop, full, empty, head_oor, tmo_hit;
    logic [31:0]   head;
    assign full     = count_q == FULL_CNT;
    assign empty    = count_q == '0;
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    // exponent field >= 128 is exactly its top bit; sign is irrelevant since cosine is even
    assign head_oor = head[30];
`ifdef CORDIC_DISPATCH_TIMEOUT_EN
    logic [4:0] tmo_q, tmo_d;
    assign tmo_d   = state_q == RUN ? tmo_q + 5'd1 : 5'd0;
    assign tmo_hit = state_q == RUN && tmo_q == 5'(TIMEOUT - 1);
    // watchdog counter, zero on the first RUN cycle
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif
    // operand storage; contents need no reset because occupancy is tracked by count_q
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end
    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // next state: screen the head in IDLE, latch the first done in RUN, hold until consumed
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        dataa_d  = dataa_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (!empty) begin
                pop = 1'b1;
                if (head_oor) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = HOLD;
                end else begin
                    dataa_d = head;
                    state_d = START;
                end
            end
            START: state_d = RUN;
            RUN: if (core_done) begin
                result_d = core_result;
                err_d    = 1'b0;
                state_d  = HOLD;
            end else if (tmo_hit) begin
                result_d = 32'h7FC0_0000;
                err_d    = 1'b1;
                state_d  = HOLD;
            end
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and result registers
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= IDLE;
            dataa_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dataa_q  <= dataa_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end
    assign core_start  = state_q == START;
    assign core_clk_en = state_q == START || state_q == RUN;
    assign core_dataa  = dataa_q;
    assign out_valid   = state_q == HOLD;
    assign out_result  = result_q;
    assign out_err     = err_q;
endmodule

// File: tb/tb_cordic_dispatch.sv
// tb_cordic_dispatch: scoreboard-checked directed tests for cordic_dispatch with a stand-in core.
module tb_cordic_dispatch;
    logic        clock = 1'b0, aclr_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, core_clk_en, core_start, core_done, out_valid, out_err;
    logic [31:0] core_dataa, core_result, out_result;
    logic        auto_mode = 1'b1, man_done = 1'b0, tmo_mode = 1'b0;
    logic [3:0]  idx = '0;
    int checks = 0, errors = 0, n_in = 0, n_out = 0, starts = 0;
    logic [32:0] exp_q[$];

    cordic_dispatch #(.FIFO_DEPTH(4), .TIMEOUT(31)) dut (
        .clock(clock), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_clk_en(core_clk_en), .core_start(core_start), .core_dataa(core_dataa),
        .core_result(core_result), .core_done(core_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_err(out_err));

    always #5 clock = ~clock;

    function automatic logic [31:0] core_fn(input logic [31:0] x);
        return x == 32'h3F00_0000 ? 32'h3F60_A8C0 : {x[31:16] ^ 16'h5A5A, x[15:0] ^ 16'hA5A5};
    endfunction

    // stand-in core: done on the 9th enabled cycle after start, recurring every 16
    always @(posedge clock) if (core_clk_en) idx <= core_start ? 4'd0 : idx + 4'd1;
    assign core_done   = auto_mode ? (core_clk_en && !core_start && idx == 4'd8) : man_done;
    assign core_result = core_fn(core_dataa);

    function automatic logic [32:0] model(input logic [31:0] x);
        if (x[30:23] >= 8'd128) return {1'b1, 32'h0};
        if (tmo_mode) return {1'b1, 32'h7FC0_0000};
        return {1'b0, core_fn(x)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard bookkeeping on handshakes
    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) exp_q.delete();
        else begin
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back(model(in_data));
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_out++;
            end
            if (core_start) starts++;
        end
    end

    // compare every cycle a result is presented
    always @(negedge clock) begin
        if (aclr_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid result %h err %b", out_result, out_err);
            end else begin
                chk("sb_out_err", {31'b0, out_err}, {31'b0, exp_q[0][32]});
                chk("sb_out_result", out_result, exp_q[0][31:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic [31:0] x);
        int k = 0;
        in_valid = 1'b1;
        in_data  = x;
        while (!in_ready && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("push_wait", {31'b0, k < 100}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!out_valid && n < lim) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_core_start"}, {31'b0, core_start}, 32'd0);
        chk({tag, "_core_clk_en"}, {31'b0, core_clk_en}, 32'd0);
        chk({tag, "_core_dataa"}, core_dataa, 32'd0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_result"}, out_result, 32'd0);
        chk({tag, "_out_err"}, {31'b0, out_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [31:0] ops [6];
        int w, s0, o0, i0;
        ops = '{32'h3E80_0000, 32'h3FFF_FFFF, 32'hBF00_0000, 32'h8000_0000, 32'hC000_0000, 32'h3F80_0000};
        #1 chk_reset("rst");
        tick(2);
        aclr_n = 1'b1;
        // single in-range operand
        push(32'h3F00_0000);
        chk("t2_start_n1", {31'b0, core_start}, 32'd0);
        tick(1);
        chk("t2_start", {31'b0, core_start}, 32'd1);
        chk("t2_dataa", core_dataa, 32'h3F00_0000);
        chk("t2_clk_en_start", {31'b0, core_clk_en}, 32'd1);
        tick(1);
        chk("t2_start_once", {31'b0, core_start}, 32'd0);
        chk("t2_clk_en_run", {31'b0, core_clk_en}, 32'd1);
        wait_valid(40, w);
        chk("t2_latency", w, 32'd9);
        chk("t2_result", out_result, 32'h3F60_A8C0);
        chk("t2_err", {31'b0, out_err}, 32'd0);
        chk("t2_hold_clk_en", {31'b0, core_clk_en}, 32'd0);
        tick(3);
        out_ready = 1'b1;
        tick(1);
        chk("t2_consumed", {31'b0, out_valid}, 32'd0);
        // out-of-range operands
        s0 = starts;
        push(32'h4000_0000);
        chk("t3_n1_valid", {31'b0, out_valid}, 32'd0);
        tick(1);
        chk("t3_n2_valid", {31'b0, out_valid}, 32'd1);
        chk("t3_err", {31'b0, out_err}, 32'd1);
        chk("t3_result", out_result, 32'd0);
        tick(1);
        push(32'h7F80_0000);
        wait_valid(5, w);
        chk("t3_inf_latency", w, 32'd1);
        chk("t3_inf_err", {31'b0, out_err}, 32'd1);
        tick(1);
        chk("t3_no_start", starts - s0, 32'd0);
        // back-pressure with a full FIFO
        out_ready = 1'b0;
        i0 = n_in;
        o0 = n_out;
        fork
            for (int i = 0; i < 6; i++) push(ops[i]);
            begin
                tick(20);
                chk("t4_accepted", n_in - i0, 32'd5);
                chk("t4_in_ready_full", {31'b0, in_ready}, 32'd0);
                chk("t4_hold", {31'b0, out_valid}, 32'd1);
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 200 && n_out - o0 < 6; k++) tick(1);
        chk("t4_results", n_out - o0, 32'd6);
        chk("t4_drained", exp_q.size(), 32'd0);
        // spurious done pulses
        auto_mode = 1'b0;
        out_ready = 1'b0;
        s0 = starts;
        o0 = n_out;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(1);
        chk("t5_idle_done", {31'b0, out_valid}, 32'd0);
        push(32'h3F00_0000);
        tick(4);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        chk("t5_latched", {31'b0, out_valid}, 32'd1);
        tick(1);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        chk("t5_hold_result", out_result, 32'h3F60_A8C0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("t5_consumed", {31'b0, out_valid}, 32'd0);
        tick(20);
        chk("t5_one_result", n_out - o0, 32'd1);
        chk("t5_one_start", starts - s0, 32'd1);
        // core never finishes
`ifdef CORDIC_DISPATCH_TIMEOUT_EN
        tmo_mode = 1'b1;
        push(32'h3E00_0000);
        tmo_mode = 1'b0;
        wait_valid(60, w);
        chk("t6_tmo_latency", w, 32'd33);
        chk("t6_tmo_err", {31'b0, out_err}, 32'd1);
        chk("t6_tmo_result", out_result, 32'h7FC0_0000);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        push(32'h3E00_0000);
        tick(5);
`else
        push(32'h3E00_0000);
        wait_valid(100, w);
        chk("t6_no_timeout", w, 32'd100);
`endif
        // reset mid-RUN with a second operand queued
        push(32'h3D00_0000);
        chk("t1_mid_run", {31'b0, core_clk_en && !core_start}, 32'd1);
        aclr_n = 1'b0;
        #1 chk_reset("mid");
        tick(2);
        aclr_n = 1'b1;
        tick(5);
        chk("t1_flushed", {31'b0, core_clk_en || out_valid}, 32'd0);
        auto_mode = 1'b1;
        push(32'h3F80_0000);
        tick(1);
        chk("t1_restart", {31'b0, core_start}, 32'd1);
        chk("t1_restart_dataa", core_dataa, 32'h3F80_0000);
        wait_valid(20, w);
        chk("t1_restart_latency", w, 32'd10);
        chk("t1_restart_err", {31'b0, out_err}, 32'd0);
        out_ready = 1'b1;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
